// File: rtl/memory_pkg.sv
// Shared types and helpers for the bidirectional-bus RAM with wait states.
package memory_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_ACK   = 2'd2,
      ST_CLEAR = 2'd3
   } state_t;

   // Ceiling log2, never narrower than one bit so it can size any vector.
   function automatic int clog2(input int value);
      int w = 0;
      while ((1 << w) < value) w++;
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/memory_bidi_ws_if.sv
// Request/response handshake of the RAM; the shared data bus stays a separate inout port.
interface memory_bidi_ws_if #(
   parameter int ADDR_W = 16
) ();
   logic              enable;
   logic              read_write;
   logic [ADDR_W-1:0] address;
   logic              ready;
   logic              fault;
   logic              busy;

   modport master (
      output enable, read_write, address,
      input  ready, fault, busy
   );

   modport slave (
      input  enable, read_write, address,
      output ready, fault, busy
   );
endinterface

// File: rtl/memory_array.sv
// Word storage: one synchronous write port and one registered read port, no reset.
module memory_array
   import memory_pkg::*;
#(
   parameter int DATA_W    = 16,
   parameter int MEM_DEPTH = 256,
   parameter int IDX_W     = clog2(MEM_DEPTH)
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic              re_i,
   input  logic [IDX_W-1:0]  idx_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [MEM_DEPTH];
   logic [DATA_W-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we_i) mem_q[idx_i] <= wdata_i;
      if (re_i) rdata_q <= mem_q[idx_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/memory_bidi_ws.sv
// Single-port RAM on a shared tri-state bus with enable/ready handshake, wait states and range fault.
// Define MEM_CLEAR_EN to zero the whole array after every reset before accepting requests.
module memory_bidi_ws
   import memory_pkg::*;
#(
   parameter int DATA_W      = 16,
   parameter int ADDR_W      = 16,
   parameter int MEM_DEPTH   = 256,
   parameter int WAIT_STATES = 1
) (
   input  logic              clk,
   input  logic              reset,
   memory_bidi_ws_if.slave   bus,
   inout  wire  [DATA_W-1:0] data
);

   localparam int               IDX_W    = clog2(MEM_DEPTH);
   localparam int               CNT_W    = clog2(WAIT_STATES + 1);
   localparam logic [ADDR_W:0]  DEPTH_A  = (ADDR_W + 1)'(MEM_DEPTH);
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_STATES);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
`ifdef MEM_CLEAR_EN
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MEM_DEPTH - 1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
   localparam state_t           ST_RESET = ST_CLEAR;
`else
   localparam state_t           ST_RESET = ST_IDLE;
`endif

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              rw_q, rw_d;
   logic              inr_q, inr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              go_ack;
   logic              req_inr;
   logic              mem_we, mem_re;
   logic [IDX_W-1:0]  mem_idx;
   logic [DATA_W-1:0] mem_wdata, mem_rdata, rd_word;
`ifdef MEM_CLEAR_EN
   logic [IDX_W-1:0]  clr_q, clr_d;
`endif

   // Full-width compare: no truncation, so high addresses never alias into the array.
   assign req_inr = ({1'b0, bus.address} < DEPTH_A);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      rw_d    = rw_q;
      inr_d   = inr_q;
      wdata_d = wdata_q;
      go_ack  = 1'b0;
`ifdef MEM_CLEAR_EN
      clr_d   = clr_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (bus.enable) begin
               idx_d   = bus.address[IDX_W-1:0];
               rw_d    = bus.read_write;
               inr_d   = req_inr;
               wdata_d = data;
               cnt_d   = CNT_INIT;
               if (WAIT_STATES == 0) begin
                  state_d = ST_ACK;
                  go_ack  = 1'b1;
               end else begin
                  state_d = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
               state_d = ST_ACK;
               go_ack  = 1'b1;
            end
         end
         ST_ACK: state_d = ST_IDLE;
`ifdef MEM_CLEAR_EN
         ST_CLEAR: begin
            clr_d = clr_q + IDX_ONE;
            if (clr_q == IDX_LAST) state_d = ST_IDLE;
         end
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   // The _d values are the request seen on the edge entering ACK, whether just accepted or latched earlier.
   always_comb begin
      mem_we    = go_ack && !rw_d && inr_d;
      mem_re    = go_ack && rw_d && inr_d;
      mem_idx   = idx_d;
      mem_wdata = wdata_d;
`ifdef MEM_CLEAR_EN
      if (state_q == ST_CLEAR) begin
         mem_we    = 1'b1;
         mem_re    = 1'b0;
         mem_idx   = clr_q;
         mem_wdata = '0;
      end
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_RESET;
         cnt_q   <= '0;
         idx_q   <= '0;
         rw_q    <= 1'b0;
         inr_q   <= 1'b0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         rw_q    <= rw_d;
         inr_q   <= inr_d;
         wdata_q <= wdata_d;
      end
   end

`ifdef MEM_CLEAR_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) clr_q <= '0;
      else       clr_q <= clr_d;
   end
`endif

   memory_array #(
      .DATA_W    (DATA_W),
      .MEM_DEPTH (MEM_DEPTH),
      .IDX_W     (IDX_W)
   ) u_array (
      .clk     (clk),
      .we_i    (mem_we),
      .re_i    (mem_re),
      .idx_i   (mem_idx),
      .wdata_i (mem_wdata),
      .rdata_o (mem_rdata)
   );

   // Out-of-range reads never loaded the read register, so force zero instead.
   assign rd_word   = inr_q ? mem_rdata : '0;
   assign data      = (state_q == ST_ACK && rw_q) ? rd_word : 'z;
   assign bus.ready = (state_q == ST_ACK);
   assign bus.fault = (state_q == ST_ACK) && !inr_q;
`ifdef MEM_CLEAR_EN
   assign bus.busy  = (state_q == ST_CLEAR);
`else
   assign bus.busy  = 1'b0;
`endif

endmodule

// File: tb/tb_memory_bidi_ws.sv
// Directed bench: one RAM with two wait states (slot 0) and one with none (slot 1); undriven bus reads as all-ones.
module tb_memory_bidi_ws;

   localparam logic [15:0] BUS_Z = 16'hFFFF;
`ifdef MEM_CLEAR_EN
   localparam logic [15:0] T3_EXP = 16'h0000;
`else
   localparam logic [15:0] T3_EXP = 16'h1357;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_bad = 0;

   memory_bidi_ws_if #(.ADDR_W(16)) bus2 ();
   memory_bidi_ws_if #(.ADDR_W(16)) bus0 ();
   tri1 [15:0] d2;
   tri1 [15:0] d0;

   logic [1:0]  en  = '0;
   logic [1:0]  rwv = '0;
   logic [1:0]  oe  = '0;
   logic [15:0] ad  [2] = '{default: '0};
   logic [15:0] wdv [2] = '{default: '0};

   assign bus2.enable     = en[0];
   assign bus2.read_write = rwv[0];
   assign bus2.address    = ad[0];
   assign bus0.enable     = en[1];
   assign bus0.read_write = rwv[1];
   assign bus0.address    = ad[1];
   assign d2 = oe[0] ? wdv[0] : 'z;
   assign d0 = oe[1] ? wdv[1] : 'z;

   logic [1:0]  rdy, flt, bsy;
   logic [15:0] dq [2];
   assign rdy   = {bus0.ready, bus2.ready};
   assign flt   = {bus0.fault, bus2.fault};
   assign bsy   = {bus0.busy, bus2.busy};
   assign dq[0] = d2;
   assign dq[1] = d0;

   memory_bidi_ws #(.DATA_W(16), .ADDR_W(16), .MEM_DEPTH(256), .WAIT_STATES(2)) u_dut2 (
      .clk(clk), .reset(rst), .bus(bus2), .data(d2)
   );
   memory_bidi_ws #(.DATA_W(16), .ADDR_W(16), .MEM_DEPTH(256), .WAIT_STATES(0)) u_dut0 (
      .clk(clk), .reset(rst), .bus(bus0), .data(d0)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      int cnt;
      en  = '0;
      oe  = '0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", rdy, 2'b00);
      chk("rst_fault", flt, 2'b00);
      chk("rst_bus_a", dq[0], BUS_Z);
      chk("rst_bus_b", dq[1], BUS_Z);
`ifdef MEM_CLEAR_EN
      chk("rst_busy", bsy, 2'b11);
`else
      chk("rst_busy", bsy, 2'b00);
`endif
      rst = 1'b0;
`ifdef MEM_CLEAR_EN
      cnt = 0;
      for (int n = 1; n <= 400; n++) begin
         @(posedge clk);
         #1;
         if (bsy == 2'b00) begin
            cnt = n;
            break;
         end
         chk("clear_no_ready", rdy, 2'b00);
         en = n[0] ? 2'b11 : 2'b00;
      end
      en = '0;
      chk("clear_cycles", cnt, 256);
`else
      cnt = 0;
      @(posedge clk);
      #1;
      chk("idle_busy", bsy | 2'(cnt), 2'b00);
`endif
   endtask

   // One transaction on slot s; mut scrambles address/data/direction during the first wait cycle.
   task automatic xact(input int s, input bit rd, input logic [15:0] a, input logic [15:0] wd,
                       input bit mut, output int lat, output logic [15:0] rdat, output logic fl);
      @(posedge clk);
      #1;
      en[s]  = 1'b1;
      rwv[s] = rd;
      ad[s]  = a;
      wdv[s] = wd;
      oe[s]  = !rd;
      lat    = 0;
      rdat   = '0;
      fl     = 1'b0;
      for (int n = 1; n <= 20; n++) begin
         @(posedge clk);
         #1;
         oe[s] = 1'b0;
         if (mut && n == 1) begin
            ad[s]  = a ^ 16'h0001;
            rwv[s] = !rd;
            wdv[s] = 16'h6666;
            oe[s]  = 1'b1;
         end
         #1;
         if (rdy[s]) begin
            lat  = n;
            rdat = dq[s];
            fl   = flt[s];
            break;
         end
         if (rd && !oe[s]) chk("bus_z_wait", dq[s], BUS_Z);
      end
      en[s] = 1'b0;
      oe[s] = 1'b0;
      @(posedge clk);
      #1;
      chk("post_ack_ready", rdy[s], 1'b0);
      chk("post_ack_bus", dq[s], BUS_Z);
   endtask

   int          lat;
   logic [15:0] rd;
   logic        f;

   initial begin
      do_reset();

`ifdef MEM_CLEAR_EN
      xact(0, 1'b1, 16'h0000, 16'h0000, 1'b0, lat, rd, f);
      chk("t5_rd0", rd, 16'h0000);
      xact(0, 1'b1, 16'h00FF, 16'h0000, 1'b0, lat, rd, f);
      chk("t5_rdff", rd, 16'h0000);
`endif

      // T1: basic write/read with two wait states
      xact(0, 1'b0, 16'h0010, 16'h1234, 1'b0, lat, rd, f);
      chk("t1_wr_lat", lat, 3);
      chk("t1_wr_fault", f, 1'b0);
      chk("t1_wr_bus", rd, BUS_Z);
      xact(0, 1'b1, 16'h0010, 16'h0000, 1'b0, lat, rd, f);
      chk("t1_rd_lat", lat, 3);
      chk("t1_rd_data", rd, 16'h1234);
      chk("t1_rd_fault", f, 1'b0);

      // T2: out of range, no aliasing onto address 0
      xact(0, 1'b0, 16'h0000, 16'h4321, 1'b0, lat, rd, f);
      xact(0, 1'b0, 16'h0100, 16'hBEEF, 1'b0, lat, rd, f);
      chk("t2_wr_lat", lat, 3);
      chk("t2_wr_fault", f, 1'b1);
      xact(0, 1'b1, 16'h0100, 16'h0000, 1'b0, lat, rd, f);
      chk("t2_rd_fault", f, 1'b1);
      chk("t2_rd_data", rd, 16'h0000);
      xact(0, 1'b1, 16'hFFFF, 16'h0000, 1'b0, lat, rd, f);
      chk("t2_rd_top_fault", f, 1'b1);
      xact(0, 1'b1, 16'h0000, 16'h0000, 1'b0, lat, rd, f);
      chk("t2_noalias", rd, 16'h4321);
      chk("t2_noalias_fault", f, 1'b0);

      // T3: reset while a write is waiting drops it
      xact(0, 1'b0, 16'h0020, 16'h1357, 1'b0, lat, rd, f);
      @(posedge clk);
      #1;
      en[0] = 1'b1; rwv[0] = 1'b0; ad[0] = 16'h0020; wdv[0] = 16'hAAAA; oe[0] = 1'b1;
      @(posedge clk);
      #1;
      oe[0] = 1'b0;
      chk("t3_wait_ready", rdy[0], 1'b0);
      rst = 1'b1;
      #1;
      chk("t3_rst_bus", dq[0], BUS_Z);
      chk("t3_rst_ready", rdy[0], 1'b0);
      for (int n = 0; n < 3; n++) begin
         @(posedge clk);
         #1;
         chk("t3_no_ready", rdy[0], 1'b0);
      end
      do_reset();
      xact(0, 1'b1, 16'h0020, 16'h0000, 1'b0, lat, rd, f);
      chk("t3_keep", rd, T3_EXP);

      // T4: zero wait states, back-to-back writes with one idle cycle
      @(posedge clk);
      #1;
      en[1] = 1'b1; rwv[1] = 1'b0; ad[1] = 16'h00FF; wdv[1] = 16'h0A0F; oe[1] = 1'b1;
      @(posedge clk);
      #1;
      chk("t4_rdy_a", rdy[1], 1'b1);
      chk("t4_fault_a", flt[1], 1'b0);
      ad[1] = 16'h0000; wdv[1] = 16'h5A5A;
      @(posedge clk);
      #1;
      chk("t4_gap", rdy[1], 1'b0);
      @(posedge clk);
      #1;
      chk("t4_rdy_b", rdy[1], 1'b1);
      chk("t4_fault_b", flt[1], 1'b0);
      en[1] = 1'b0; oe[1] = 1'b0;
      @(posedge clk);
      #1;
      chk("t4_idle", rdy[1], 1'b0);
      xact(1, 1'b1, 16'h00FF, 16'h0000, 1'b0, lat, rd, f);
      chk("t4_rd_lat", lat, 1);
      chk("t4_rd_ff", rd, 16'h0A0F);
      chk("t4_rd_ff_fault", f, 1'b0);
      xact(1, 1'b1, 16'h0000, 16'h0000, 1'b0, lat, rd, f);
      chk("t4_rd_00", rd, 16'h5A5A);
      xact(1, 1'b1, 16'h0100, 16'h0000, 1'b0, lat, rd, f);
      chk("t4_oor_lat", lat, 1);
      chk("t4_oor_fault", f, 1'b1);
      chk("t4_oor_data", rd, 16'h0000);

      // T6: request fields changing during WAIT are ignored
      xact(0, 1'b0, 16'h0031, 16'h1111, 1'b0, lat, rd, f);
      xact(0, 1'b0, 16'h0030, 16'h5555, 1'b1, lat, rd, f);
      chk("t6_wr_lat", lat, 3);
      chk("t6_wr_bus", rd, BUS_Z);
      xact(0, 1'b1, 16'h0031, 16'h0000, 1'b0, lat, rd, f);
      chk("t6_other_a", rd, 16'h1111);
      xact(0, 1'b1, 16'h0030, 16'h0000, 1'b1, lat, rd, f);
      chk("t6_rd_lat", lat, 3);
      chk("t6_rd_data", rd, 16'h5555);
      xact(0, 1'b1, 16'h0031, 16'h0000, 1'b0, lat, rd, f);
      chk("t6_other_b", rd, 16'h1111);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
